// File: rtl/axi4l_master.sv
// rtl/axi4l_master.sv - single-outstanding AXI4-Lite master behind a valid/ready command and response port
module axi4l_master #(
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter logic [2:0]  C_PROT       = 3'b000
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [31:0]               cmd_addr,
    input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [31:0]               m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [C_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [31:0]               m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [C_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int unsigned STRB_W = C_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_RST, S_IDLE, S_WRITE, S_WRESP, S_READ, S_RRESP, S_CMPL
    } state_t;

    state_t                    state_q, state_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      arvalid_q, arvalid_d;
    logic                      bready_q, bready_d;
    logic                      rready_q, rready_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [31:0]               awaddr_q, awaddr_d;
    logic [C_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]         wstrb_q, wstrb_d;
    logic [31:0]               araddr_q, araddr_d;
    logic                      rsp_write_q, rsp_write_d;
    logic [C_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                rsp_resp_q, rsp_resp_d;
    logic                      aw_done, w_done;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= S_RST;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            araddr_q    <= '0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            araddr_q    <= araddr_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        araddr_d    = araddr_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        aw_done     = 1'b0;
        w_done      = 1'b0;

        case (state_q)
            S_RST: state_d = S_IDLE;
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WRITE;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = S_READ;
                    end
                end
            end
            S_WRITE: begin
                // AW and W complete independently; a channel already done stays done
                aw_done = !awvalid_q || m_axi_awready;
                w_done  = !wvalid_q || m_axi_wready;
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done)          state_d   = S_WRESP;
            end
            S_WRESP: begin
                if (m_axi_bvalid) begin
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axi_bresp;
                    state_d     = S_CMPL;
                end
            end
            S_READ: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RRESP;
                end
            end
            S_RRESP: begin
                if (m_axi_rvalid) begin
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    state_d     = S_CMPL;
                end
            end
            S_CMPL: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_RST;
        endcase

        // Channel readies and rsp_valid are registered copies of the next state
        bready_d    = (state_d == S_WRESP);
        rready_d    = (state_d == S_RRESP);
        rsp_valid_d = (state_d == S_CMPL);
    end

    assign cmd_ready     = (state_q == S_IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = C_PROT;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = C_PROT;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi4l_master.sv
// tb/tb_axi4l_master.sv - self-checking bench for axi4l_master with a reactive register slave
`timescale 1ns/1ps
module tb_axi4l_master;

    localparam int DW = 32;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [31:0]   cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [31:0]   awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, wvalid, arvalid, bready, rready;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          awready = 1'b0, wready = 1'b0, arready = 1'b0;
    logic [1:0]    bresp = '0, rresp = '0;
    logic          bvalid = 1'b0, rvalid = 1'b0;
    logic [DW-1:0] rdata = '0;

    axi4l_master #(.C_DATA_WIDTH(DW), .C_PROT(3'b000)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endfunction

    // Slave configuration (changed only at negedges) and slave state
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_wait = 0, r_wait = 0;
    bit          got_aw = 0, got_w = 0, b_pend = 0, r_pend = 0;
    logic [31:0] mem [0:1] = '{32'h0, 32'h0};
    logic [31:0] sa_addr = '0, sw_data = '0, sar_addr = '0, r_hold = '0;
    logic [3:0]  sw_strb = '0;
    bit          s_hs_aw = 0, s_hs_w = 0, s_hs_ar = 0, s_hs_b = 0, s_hs_r = 0;
    bit          s_awv = 0, s_wv = 0, s_arv = 0, s_rst = 1;

    // Expected DUT outputs for the current cycle
    logic        e_cmd_ready = 0, e_awvalid = 0, e_wvalid = 0, e_arvalid = 0;
    logic        e_bready = 0, e_rready = 0, e_rsp_valid = 0, e_rsp_write = 0;
    logic [31:0] e_awaddr = '0, e_araddr = '0, e_wdata = '0, e_rsp_rdata = '0;
    logic [3:0]  e_wstrb = '0;
    logic [1:0]  e_rsp_resp = '0;
    bit          in_rst = 1, wphase = 0;
    logic [31:0] rq [$];

    always @(negedge aclk) begin
        chk("cmd_ready", cmd_ready, e_cmd_ready);
        chk("awvalid", awvalid, e_awvalid);
        chk("wvalid", wvalid, e_wvalid);
        chk("arvalid", arvalid, e_arvalid);
        chk("bready", bready, e_bready);
        chk("rready", rready, e_rready);
        chk("rsp_valid", rsp_valid, e_rsp_valid);
        chk("rsp_write", rsp_write, e_rsp_write);
        chk("rsp_rdata", rsp_rdata, e_rsp_rdata);
        chk("rsp_resp", rsp_resp, e_rsp_resp);
        chk("awaddr", awaddr, e_awaddr);
        chk("wdata", wdata, e_wdata);
        chk("wstrb", wstrb, e_wstrb);
        chk("araddr", araddr, e_araddr);
        chk("prot", {awprot, arprot}, 6'd0);

        if (rsp_valid && rsp_ready && !rsp_write) rq.push_back(rsp_rdata);

        s_rst   = areset;
        s_awv   = awvalid;
        s_wv    = wvalid;
        s_arv   = arvalid;
        s_hs_aw = awvalid && awready;
        s_hs_w  = wvalid && wready;
        s_hs_ar = arvalid && arready;
        s_hs_b  = bvalid && bready;
        s_hs_r  = rvalid && rready;
        if (s_hs_aw) sa_addr = awaddr;
        if (s_hs_w) begin sw_data = wdata; sw_strb = wstrb; end
        if (s_hs_ar) sar_addr = araddr;

        if (areset) begin
            {e_cmd_ready, e_awvalid, e_wvalid, e_arvalid, e_bready, e_rready, e_rsp_valid} = '0;
            {e_awaddr, e_araddr, e_wdata, e_wstrb, e_rsp_write, e_rsp_rdata, e_rsp_resp} = '0;
            in_rst = 1;
            wphase = 0;
        end else if (in_rst) begin
            in_rst = 0;
            e_cmd_ready = 1;
        end else if (e_cmd_ready && cmd_valid) begin
            e_cmd_ready = 0;
            if (cmd_write) begin
                e_awvalid = 1; e_wvalid = 1; wphase = 1;
                e_awaddr = cmd_addr; e_wdata = cmd_wdata; e_wstrb = cmd_wstrb;
            end else begin
                e_arvalid = 1;
                e_araddr = cmd_addr;
            end
        end else begin
            if (e_rsp_valid && rsp_ready) begin
                e_rsp_valid = 0;
                e_cmd_ready = 1;
            end
            if (e_awvalid && awready) e_awvalid = 0;
            if (e_wvalid && wready) e_wvalid = 0;
            if (wphase && !e_awvalid && !e_wvalid) begin
                wphase = 0;
                e_bready = 1;
            end else if (e_bready && bvalid) begin
                e_bready = 0; e_rsp_valid = 1;
                e_rsp_write = 1; e_rsp_rdata = '0; e_rsp_resp = bresp;
            end
            if (e_arvalid && arready) begin
                e_arvalid = 0;
                e_rready = 1;
            end else if (e_rready && rvalid) begin
                e_rready = 0; e_rsp_valid = 1;
                e_rsp_write = 0; e_rsp_rdata = rdata; e_rsp_resp = rresp;
            end
        end
    end

    // Register slave: two 32-bit words selected by address bit 2
    always @(posedge aclk) begin
        #1;
        if (s_rst) begin
            {awready, wready, arready, bvalid, rvalid} = '0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
        end else begin
            if (s_hs_b) bvalid = 0;
            if (s_hs_r) rvalid = 0;
            if (s_hs_aw) begin got_aw = 1; aw_cnt = 0; end else if (s_awv) aw_cnt++;
            if (s_hs_w) begin got_w = 1; w_cnt = 0; end else if (s_wv) w_cnt++;
            if (s_hs_ar) begin
                r_pend = 1; r_wait = r_delay; ar_cnt = 0;
                r_hold = mem[sar_addr[2]];
            end else if (s_arv) ar_cnt++;
            if (got_aw && got_w) begin
                for (int b = 0; b < 4; b++)
                    if (sw_strb[b]) mem[sa_addr[2]][8*b +: 8] = sw_data[8*b +: 8];
                got_aw = 0; got_w = 0; b_pend = 1; b_wait = b_delay;
            end
            if (b_pend) begin
                if (b_wait == 0) begin bvalid = 1; bresp = cfg_bresp; b_pend = 0; end
                else b_wait--;
            end
            if (r_pend) begin
                if (r_wait == 0) begin rvalid = 1; rdata = r_hold; rresp = cfg_rresp; r_pend = 0; end
                else r_wait--;
            end
            awready = awvalid && (aw_cnt >= aw_delay);
            wready  = wvalid && (w_cnt >= w_delay);
            arready = arvalid && (ar_cnt >= ar_delay);
        end
    end

    task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int acc);
        bit got;
        got = 0;
        acc = -1;
        @(posedge aclk); #1;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        for (int k = 0; k < 50; k++) begin
            @(negedge aclk);
            if (cmd_ready) begin acc = cyc; got = 1; break; end
        end
        chk("cmd_accept", got, 1);
    endtask

    task automatic idle_cmd();
        @(posedge aclk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_cyc(input int n);
        do @(negedge aclk); while (cyc < n);
        chk("cycle_align", cyc, n);
    endtask

    int c0, r;
    int acc [16];
    logic [31:0] exp_q [$];
    logic [31:0] wd;

    initial begin
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'd0);
        chk("rst_payload", {awaddr, araddr, rsp_rdata}, 96'd0);
        @(posedge aclk); #1 areset = 0;
        @(negedge aclk); chk("rel_cmd_ready_c1", cmd_ready, 0);
        @(negedge aclk); chk("rel_cmd_ready_c2", cmd_ready, 1);

        // Zero-wait write
        send_cmd(1, 32'h4, 32'hDEADBEEF, 4'hF, c0);
        idle_cmd();
        wait_cyc(c0 + 1);
        chk("w0_awvalid", {awvalid, wvalid}, 2'b11);
        chk("w0_awaddr", awaddr, 32'h4);
        chk("w0_wdata", wdata, 32'hDEADBEEF);
        chk("w0_wstrb", wstrb, 4'hF);
        wait_cyc(c0 + 2); chk("w0_bready", bready, 1);
        wait_cyc(c0 + 3);
        chk("w0_rsp_valid", rsp_valid, 1);
        chk("w0_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b1, 2'b00, 32'h0});

        // Delayed read of a word written just before
        ar_delay = 3; r_delay = 2;
        send_cmd(1, 32'h4, 32'h12345678, 4'hF, c0);
        idle_cmd();
        send_cmd(0, 32'h4, 32'h0, 4'h0, c0);
        idle_cmd();
        for (int k = 1; k <= 4; k++) begin
            wait_cyc(c0 + k);
            chk("rd_arvalid_held", arvalid, 1);
            chk("rd_araddr", araddr, 32'h4);
        end
        wait_cyc(c0 + 5); chk("rd_rready", {arvalid, rready}, 2'b01);
        wait_cyc(c0 + 8);
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp", {rsp_write, rsp_resp, rsp_rdata}, {1'b0, 2'b00, 32'h12345678});
        ar_delay = 0; r_delay = 0;

        // Split write handshakes: W at cycle 1, AW at cycle 4
        aw_delay = 3;
        send_cmd(1, 32'h0, 32'hA5A5_0001, 4'h3, c0);
        idle_cmd();
        wait_cyc(c0 + 2); chk("sp_c2", {awvalid, wvalid}, 2'b10);
        wait_cyc(c0 + 4); chk("sp_c4", {awvalid, bready}, 2'b10);
        wait_cyc(c0 + 5); chk("sp_c5", {awvalid, bready}, 2'b01);
        wait_cyc(c0 + 6); chk("sp_rsp", {rsp_valid, rsp_write}, 2'b11);
        aw_delay = 0;

        // SLVERR/DECERR passthrough with response backpressure
        cfg_rresp = 2'b11;
        @(posedge aclk); #1 rsp_ready = 0;
        send_cmd(0, 32'h0, 32'h0, 4'h0, c0);
        idle_cmd();
        r = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge aclk);
            if (rsp_valid) begin r = cyc; break; end
        end
        chk("err_rsp_cycle", r, c0 + 3);
        chk("err_c0", {rsp_resp, cmd_ready}, 3'b110);
        for (int k = 1; k <= 3; k++) begin
            wait_cyc(r + k);
            chk("err_hold", {rsp_valid, rsp_resp, cmd_ready}, 4'b1110);
        end
        @(posedge aclk); #1 rsp_ready = 1;
        wait_cyc(r + 4); chk("err_consume", {rsp_valid, rsp_resp, cmd_ready}, 4'b1110);
        wait_cyc(r + 5); chk("err_after", {rsp_valid, cmd_ready}, 2'b01);
        cfg_rresp = 2'b00;

        // Reset while AW is still pending
        aw_delay = 10;
        send_cmd(1, 32'h4, 32'h0BADF00D, 4'hF, c0);
        idle_cmd();
        wait_cyc(c0 + 1); chk("mr_awvalid", awvalid, 1);
        @(posedge aclk); #1 areset = 1;
        wait_cyc(c0 + 3);
        chk("mr_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, 7'd0);
        @(posedge aclk); #1 areset = 0;
        wait_cyc(c0 + 4); chk("mr_cmd_ready_c1", cmd_ready, 0);
        wait_cyc(c0 + 5); chk("mr_cmd_ready_c2", cmd_ready, 1);
        aw_delay = 0;

        // Back-to-back alternating write/read against a registered slave
        b_delay = 1; r_delay = 1;
        rq.delete();
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                wd = $urandom;
                exp_q.push_back(wd);
                send_cmd(1, ((i / 2) % 2) * 4, wd, 4'hF, acc[i]);
            end else begin
                send_cmd(0, ((i / 2) % 2) * 4, 32'h0, 4'h0, acc[i]);
            end
        end
        idle_cmd();
        for (int i = 1; i < 16; i++) chk("b2b_ii", acc[i] - acc[i-1], 5);
        for (int k = 0; k < 100 && rq.size() < 8; k++) @(negedge aclk);
        chk("b2b_rsp_count", rq.size(), 8);
        for (int i = 0; i < 8 && i < rq.size(); i++) chk("b2b_rdata", rq[i], exp_q[i]);

        repeat (3) @(negedge aclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
